// File: rtl/if_fetch_pc.sv
// rtl/if_fetch_pc.sv - Two-wide fetch PC generator and IF/ID pipeline register
module if_fetch_pc #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_INST = 32'h47ff041f
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        recover,
    input  logic [63:0] recover_target,
    input  logic        halt_req,
    input  logic        id_stall,
    input  logic        imem_valid,
    input  logic [63:0] imem_data,
    input  logic [63:0] btb_pred_addr0,
    input  logic [63:0] btb_pred_addr1,
    input  logic        bp_taken0,
    input  logic        bp_taken1,
    output logic [63:0] if_NPC0,
    output logic [63:0] if_NPC1,
    output logic        id_valid0,
    output logic        id_valid1,
    output logic [31:0] id_inst0,
    output logic [31:0] id_inst1,
    output logic [63:0] id_PC0,
    output logic [63:0] id_PC1,
    output logic [63:0] id_pred_npc0,
    output logic [63:0] id_pred_npc1,
    output logic        if_halted
);

    typedef enum logic {
        S_FETCH  = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    localparam logic [63:0] ALIGN_MASK = ~64'h3;

    state_t      state_q;
    logic [63:0] pc_q;
    logic [63:0] pc_d;
    logic        id_valid0_q;
    logic        id_valid1_q;
    logic [31:0] id_inst0_q;
    logic [31:0] id_inst1_q;
    logic [63:0] id_pc0_q;
    logic [63:0] id_pc1_q;
    logic [63:0] id_pn0_q;
    logic [63:0] id_pn1_q;

    logic        v0;
    logic        v1;
    logic        fetch_en;
    logic [31:0] slot0_inst;
    logic [31:0] slot1_inst;
    logic [63:0] pc_plus4;
    logic [63:0] pc_plus8;
    logic [63:0] pn0;
    logic [63:0] pn1;

    assign pc_plus4 = pc_q + 64'd4;
    assign pc_plus8 = pc_q + 64'd8;

    // An upper-half PC fetches one instruction; a taken slot 0 kills slot 1.
    assign v0 = imem_valid;
    assign v1 = imem_valid & ~pc_q[2] & ~(bp_taken0 & v0);

    assign slot0_inst = pc_q[2] ? imem_data[63:32] : imem_data[31:0];
    assign slot1_inst = v1 ? imem_data[63:32] : NOP_INST;

    assign pn0 = bp_taken0 ? (btb_pred_addr0 & ALIGN_MASK) : pc_plus4;
    assign pn1 = bp_taken1 ? (btb_pred_addr1 & ALIGN_MASK) : pc_plus8;

    assign fetch_en = (state_q == S_FETCH) & imem_valid;

    always_comb begin
        pc_d = pc_q;
        if (recover) begin
            pc_d = recover_target & ALIGN_MASK;
        end else if (!fetch_en || id_stall) begin
            pc_d = pc_q;
        end else if (v0 && bp_taken0) begin
            pc_d = pn0;
        end else if (v1) begin
            pc_d = pn1;
        end else begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            id_valid0_q <= 1'b0;
            id_valid1_q <= 1'b0;
            id_inst0_q  <= NOP_INST;
            id_inst1_q  <= NOP_INST;
            id_pc0_q    <= 64'h0;
            id_pc1_q    <= 64'h0;
            id_pn0_q    <= 64'h0;
            id_pn1_q    <= 64'h0;
        end else begin
            pc_q <= pc_d;

            if (recover) begin
                state_q <= S_FETCH;
            end else if (halt_req) begin
                state_q <= S_HALTED;
            end

            // Flush wins over stall so the redirect and the squash land together.
            if (recover) begin
                id_valid0_q <= 1'b0;
                id_valid1_q <= 1'b0;
            end else if (!id_stall) begin
                if (fetch_en) begin
                    id_valid0_q <= v0;
                    id_valid1_q <= v1;
                    id_inst0_q  <= slot0_inst;
                    id_inst1_q  <= slot1_inst;
                    id_pc0_q    <= pc_q;
                    id_pc1_q    <= pc_plus4;
                    id_pn0_q    <= pn0;
                    id_pn1_q    <= pn1;
                end else begin
                    id_valid0_q <= 1'b0;
                    id_valid1_q <= 1'b0;
                end
            end
        end
    end

    assign if_NPC0      = pc_q;
    assign if_NPC1      = pc_plus4;
    assign id_valid0    = id_valid0_q;
    assign id_valid1    = id_valid1_q;
    assign id_inst0     = id_inst0_q;
    assign id_inst1     = id_inst1_q;
    assign id_PC0       = id_pc0_q;
    assign id_PC1       = id_pc1_q;
    assign id_pred_npc0 = id_pn0_q;
    assign id_pred_npc1 = id_pn1_q;
    assign if_halted    = (state_q == S_HALTED);

endmodule

// File: tb/tb_if_fetch_pc.sv
// tb/tb_if_fetch_pc.sv - Directed and random checks of if_fetch_pc against a reference model
module tb_if_fetch_pc;

    localparam logic [63:0] RST_PC = 64'h0;
    localparam logic [31:0] NOP    = 32'h47ff041f;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        recover = 1'b0;
    logic [63:0] recover_target = 64'h0;
    logic        halt_req = 1'b0;
    logic        id_stall = 1'b0;
    logic        imem_valid = 1'b0;
    logic [63:0] imem_data = 64'h0;
    logic [63:0] btb_pred_addr0 = 64'h0;
    logic [63:0] btb_pred_addr1 = 64'h0;
    logic        bp_taken0 = 1'b0;
    logic        bp_taken1 = 1'b0;

    logic [63:0] if_NPC0, if_NPC1;
    logic        id_valid0, id_valid1;
    logic [31:0] id_inst0, id_inst1;
    logic [63:0] id_PC0, id_PC1, id_pred_npc0, id_pred_npc1;
    logic        if_halted;

    int errors = 0;
    int checks = 0;

    // Reference state: fetch address, halt flag and the decode-side slot record.
    logic [63:0] m_pc;
    logic        m_halt;
    logic        m_v0, m_v1;
    logic [31:0] m_i0, m_i1;
    logic [63:0] m_pc0, m_pc1, m_pn0, m_pn1;

    if_fetch_pc #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clock(clock), .reset(reset), .recover(recover), .recover_target(recover_target),
        .halt_req(halt_req), .id_stall(id_stall), .imem_valid(imem_valid), .imem_data(imem_data),
        .btb_pred_addr0(btb_pred_addr0), .btb_pred_addr1(btb_pred_addr1),
        .bp_taken0(bp_taken0), .bp_taken1(bp_taken1),
        .if_NPC0(if_NPC0), .if_NPC1(if_NPC1), .id_valid0(id_valid0), .id_valid1(id_valid1),
        .id_inst0(id_inst0), .id_inst1(id_inst1), .id_PC0(id_PC0), .id_PC1(id_PC1),
        .id_pred_npc0(id_pred_npc0), .id_pred_npc1(id_pred_npc1), .if_halted(if_halted)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [63:0] n_pc, n_pc0, n_pc1, n_pn0, n_pn1, t0, t1;
        logic        n_halt, n_v0, n_v1, two_wide;
        logic [31:0] n_i0, n_i1;
        n_pc = m_pc; n_halt = m_halt; n_v0 = m_v0; n_v1 = m_v1;
        n_i0 = m_i0; n_i1 = m_i1; n_pc0 = m_pc0; n_pc1 = m_pc1; n_pn0 = m_pn0; n_pn1 = m_pn1;
        if (reset) begin
            n_pc = RST_PC; n_halt = 1'b0; n_v0 = 1'b0; n_v1 = 1'b0;
            n_i0 = NOP; n_i1 = NOP; n_pc0 = 0; n_pc1 = 0; n_pn0 = 0; n_pn1 = 0;
        end else begin
            t0 = {btb_pred_addr0[63:2], 2'b00};
            t1 = {btb_pred_addr1[63:2], 2'b00};
            two_wide = (m_pc % 8 == 0) && !bp_taken0;
            if (recover)                               n_pc = {recover_target[63:2], 2'b00};
            else if (m_halt || id_stall || !imem_valid) n_pc = m_pc;
            else if (bp_taken0)                        n_pc = t0;
            else if (two_wide)                         n_pc = bp_taken1 ? t1 : m_pc + 8;
            else                                       n_pc = m_pc + 4;
            if (recover) begin
                n_v0 = 1'b0; n_v1 = 1'b0;
            end else if (!id_stall) begin
                if (m_halt || !imem_valid) begin
                    n_v0 = 1'b0; n_v1 = 1'b0;
                end else begin
                    n_v0  = 1'b1;
                    n_v1  = two_wide;
                    n_i0  = (m_pc % 8 == 4) ? imem_data[63:32] : imem_data[31:0];
                    n_i1  = two_wide ? imem_data[63:32] : NOP;
                    n_pc0 = m_pc;
                    n_pc1 = m_pc + 4;
                    n_pn0 = bp_taken0 ? t0 : m_pc + 4;
                    n_pn1 = bp_taken1 ? t1 : m_pc + 8;
                end
            end
            if (recover)       n_halt = 1'b0;
            else if (halt_req) n_halt = 1'b1;
        end
        @(posedge clock);
        #1;
        m_pc = n_pc; m_halt = n_halt; m_v0 = n_v0; m_v1 = n_v1; m_i0 = n_i0; m_i1 = n_i1;
        m_pc0 = n_pc0; m_pc1 = n_pc1; m_pn0 = n_pn0; m_pn1 = n_pn1;
        chk("if_NPC0", if_NPC0, m_pc);
        chk("if_NPC1", if_NPC1, m_pc + 64'd4);
        chk("id_valid0", {63'b0, id_valid0}, {63'b0, m_v0});
        chk("id_valid1", {63'b0, id_valid1}, {63'b0, m_v1});
        chk("id_inst0", {32'b0, id_inst0}, {32'b0, m_i0});
        chk("id_inst1", {32'b0, id_inst1}, {32'b0, m_i1});
        chk("id_PC0", id_PC0, m_pc0);
        chk("id_PC1", id_PC1, m_pc1);
        chk("id_pred_npc0", id_pred_npc0, m_pn0);
        chk("id_pred_npc1", id_pred_npc1, m_pn1);
        chk("if_halted", {63'b0, if_halted}, {63'b0, m_halt});
    endtask

    initial begin
        m_pc = 0; m_halt = 0; m_v0 = 0; m_v1 = 0; m_i0 = NOP; m_i1 = NOP;
        m_pc0 = 0; m_pc1 = 0; m_pn0 = 0; m_pn1 = 0;
        #1;

        // Reset state
        reset = 1'b1; imem_valid = 1'b1; imem_data = 64'h11111111_22222222;
        step();
        chk("rst_pc", if_NPC0, 64'h0);
        chk("rst_inst0", {32'b0, id_inst0}, {32'b0, 32'h47ff041f});
        chk("rst_valid0", {63'b0, id_valid0}, 64'h0);
        reset = 1'b0;

        // Sequential two-wide fetch
        step();
        chk("seq_pc8", if_NPC0, 64'h8);
        chk("seq_idpc0", id_PC0, 64'h0);
        chk("seq_idpc1", id_PC1, 64'h4);
        chk("seq_pn1_8", id_pred_npc1, 64'h8);
        chk("seq_v1", {63'b0, id_valid1}, 64'h1);
        chk("seq_inst1", {32'b0, id_inst1}, 64'h11111111);
        step();
        chk("seq_pc16", if_NPC0, 64'h10);
        chk("seq_idpc0_8", id_PC0, 64'h8);
        chk("seq_pn1_16", id_pred_npc1, 64'h10);

        // Slot 0 predicted taken, target alignment
        recover = 1'b1; recover_target = 64'h20;
        step();
        recover = 1'b0; bp_taken0 = 1'b1; btb_pred_addr0 = 64'h103;
        step();
        chk("tk_pc", if_NPC0, 64'h100);
        chk("tk_v1", {63'b0, id_valid1}, 64'h0);
        chk("tk_pn0", id_pred_npc0, 64'h100);
        bp_taken0 = 1'b0;

        // Upper-half fetch
        recover = 1'b1; recover_target = 64'h104;
        step();
        recover = 1'b0; imem_data = 64'hAAAAAAAA_BBBBBBBB;
        step();
        chk("hi_inst0", {32'b0, id_inst0}, 64'hAAAAAAAA);
        chk("hi_v1", {63'b0, id_valid1}, 64'h0);
        chk("hi_pc", if_NPC0, 64'h108);

        // Stall holds everything
        id_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            imem_data = {$urandom(), $urandom()};
            step();
            chk("stl_idpc0", id_PC0, 64'h104);
            chk("stl_pc", if_NPC0, 64'h108);
        end
        id_stall = 1'b0;
        step();
        chk("rel_idpc0", id_PC0, 64'h108);
        chk("rel_pc", if_NPC0, 64'h110);

        // Recover beats stall and halt
        recover = 1'b1; recover_target = 64'h400; id_stall = 1'b1; halt_req = 1'b1;
        step();
        chk("rec_v0", {63'b0, id_valid0}, 64'h0);
        chk("rec_pc", if_NPC0, 64'h400);
        chk("rec_halt", {63'b0, if_halted}, 64'h0);
        recover = 1'b0; id_stall = 1'b0;

        // Halt and resume
        step();
        chk("hlt_on", {63'b0, if_halted}, 64'h1);
        chk("hlt_pc", if_NPC0, 64'h408);
        halt_req = 1'b0;
        step();
        chk("hlt_v0", {63'b0, id_valid0}, 64'h0);
        chk("hlt_hold", if_NPC0, 64'h408);
        recover = 1'b1; recover_target = 64'h40;
        step();
        chk("res_pc", if_NPC0, 64'h40);
        chk("res_halt", {63'b0, if_halted}, 64'h0);
        recover = 1'b0;
        step();
        chk("res_idpc0", id_PC0, 64'h40);
        chk("res_v0", {63'b0, id_valid0}, 64'h1);

        // Memory bubble
        imem_valid = 1'b0;
        step();
        chk("bub_v0", {63'b0, id_valid0}, 64'h0);
        chk("bub_pc", if_NPC0, 64'h48);
        imem_valid = 1'b1;

        // Address wrap-around
        recover = 1'b1; recover_target = 64'hFFFF_FFFF_FFFF_FFFB;
        step();
        chk("wr_pc", if_NPC0, 64'hFFFF_FFFF_FFFF_FFF8);
        recover = 1'b0;
        step();
        chk("wr_pc0", if_NPC0, 64'h0);
        chk("wr_idpc1", id_PC1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wr_pn1", id_pred_npc1, 64'h0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 59) == 0);
            recover        = ($urandom_range(0, 11) == 0);
            recover_target = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF4 + 64'($urandom_range(0, 7))
                                                         : {$urandom(), $urandom()};
            halt_req       = ($urandom_range(0, 19) == 0);
            id_stall       = ($urandom_range(0, 4) == 0);
            imem_valid     = ($urandom_range(0, 5) != 0);
            imem_data      = {$urandom(), $urandom()};
            btb_pred_addr0 = {$urandom(), $urandom()};
            btb_pred_addr1 = {$urandom(), $urandom()};
            bp_taken0      = ($urandom_range(0, 3) == 0);
            bp_taken1      = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
